// File: rtl/modulo_decodificador_display_garrafas_pkg.sv
// ---------------------------------------------------------------------------
// Shared definitions for the bottle-count display receiver.
//
// Holds the scan state encoding, the two fixed segment patterns that are not
// digits (fully dark and dash), and the code-validity test. The display top
// and the 7-segment decoder both import this package.
//
// Contents:
//   estado_t        2-bit scan state (EXIBE_UNI=0, APAGA_1=1, EXIBE_DEZ=2, APAGA_2=3)
//   SEG_APAGADO     all segments off (active-low)
//   SEG_TRACO       only segment g lit, a dash shown for an invalid code
//   codigo_valido   1 when a 4-bit code carries a decimal digit 0..9
// ---------------------------------------------------------------------------
package modulo_decodificador_display_garrafas_pkg;

    typedef enum logic [1:0] {
        EXIBE_UNI = 2'd0,
        APAGA_1   = 2'd1,
        EXIBE_DEZ = 2'd2,
        APAGA_2   = 2'd3
    } estado_t;

    localparam logic [6:0] SEG_APAGADO = 7'h7F;
    localparam logic [6:0] SEG_TRACO   = 7'h3F;

    // Codes 0..9 map one-to-one onto BCD digits; 10..15 never come from a
    // healthy encoder and are treated as transmission errors.
    function automatic logic codigo_valido(input logic [3:0] codigo);
        return (codigo <= 4'd9);
    endfunction

endpackage

// File: rtl/modulo_decodificador_display_garrafas_7seg.sv
// ---------------------------------------------------------------------------
// modulo_decodificador_7seg
//
// Purely combinational: turns one encoded digit code into the active-low
// segment pattern for a common-anode display. Any code outside 0..9 shows a
// dash so a bad transmission is visible on the panel instead of a random
// glyph.
//
// Ports:
//   codigo  in   4  encoded digit code
//   seg     out  7  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module modulo_decodificador_7seg
    import modulo_decodificador_display_garrafas_pkg::*;
(
    input  logic [3:0] codigo,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TRACO;
        if (codigo_valido(codigo)) begin
            case (codigo)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = SEG_TRACO;
            endcase
        end
    end

endmodule

// File: rtl/modulo_decodificador_display_garrafas.sv
// ---------------------------------------------------------------------------
// modulo_decodificador_display_garrafas
//
// Receive end of the bottle-count path. A load strobe captures the encoded
// units/tens codes, flags the pair as erroneous when either code is out of
// range, and a scan FSM time-multiplexes the two digits onto a common-anode
// 7-segment display with an optional dark guard slot between digits to stop
// ghosting.
//
// Parameters:
//   DIVISOR       cycles each digit stays lit per scan slot (>=1)
//   GUARDA        dark cycles between digit slots; 0 removes the dark slots
//   SUPRIME_ZERO  1 = a valid tens digit of 0 is shown dark
//
// Ports:
//   clk          in   1  system clock, rising edge
//   reset_n      in   1  synchronous reset, active-low
//   carregar     in   1  load strobe for cdf_unidade/cdf_dezena
//   cdf_unidade  in   4  encoded units code
//   cdf_dezena   in   4  encoded tens code
//   segmentos    out  7  {g,f,e,d,c,b,a}, active-low
//   anodos       out  2  digit enables, active-low; [0]=units, [1]=tens
//   erro         out  1  last loaded pair held an invalid code
// ---------------------------------------------------------------------------
module modulo_decodificador_display_garrafas
    import modulo_decodificador_display_garrafas_pkg::*;
#(
    parameter int DIVISOR      = 50000,
    parameter int GUARDA       = 4,
    parameter int SUPRIME_ZERO = 1
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       carregar,
    input  logic [3:0] cdf_unidade,
    input  logic [3:0] cdf_dezena,
    output logic [6:0] segmentos,
    output logic [1:0] anodos,
    output logic       erro
);

    // The slot counter only ever has to reach DIVISOR-1; the guard slot is
    // folded into the same counter, so the width covers whichever is longer.
    localparam int MAIOR_SLOT = (DIVISOR > GUARDA) ? DIVISOR : GUARDA;
    localparam int CNT_W      = $clog2(MAIOR_SLOT + 1);

    localparam logic [CNT_W-1:0] FIM_EXIBE = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] FIM_APAGA = CNT_W'((GUARDA > 0) ? GUARDA - 1 : 0);

    estado_t          estado;
    estado_t          proximo;
    logic [CNT_W-1:0] contagem;
    logic [3:0]       digito_uni;
    logic [3:0]       digito_dez;
    logic [3:0]       digito_sel;
    logic [6:0]       seg_decod;
    logic             saida_bloqueada;

    // One shared decoder; the scan state picks which stored code feeds it.
    assign digito_sel = (estado == EXIBE_DEZ) ? digito_dez : digito_uni;

    modulo_decodificador_7seg u_decod (
        .codigo (digito_sel),
        .seg    (seg_decod)
    );

    // State register plus the load path. saida_bloqueada is set on every
    // reset edge and keeps the pins dark for the cycle that follows; the
    // scan is frozen during that cycle so the first visible units slot
    // starts with a count of 0 and lasts the full DIVISOR cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado          <= EXIBE_UNI;
            contagem        <= '0;
            digito_uni      <= 4'd0;
            digito_dez      <= 4'd0;
            erro            <= 1'b0;
            saida_bloqueada <= 1'b1;
        end else begin
            saida_bloqueada <= 1'b0;
            if (carregar) begin
                digito_uni <= cdf_unidade;
                digito_dez <= cdf_dezena;
                erro       <= !(codigo_valido(cdf_unidade) && codigo_valido(cdf_dezena));
            end
            if (!saida_bloqueada) begin
                estado <= proximo;
                if (proximo != estado) begin
                    contagem <= '0;
                end else begin
                    contagem <= contagem + 1'b1;
                end
            end
        end
    end

    // Next-state and pin drive. Outputs depend only on registered state, so
    // nothing on the input side can glitch the display pins.
    always_comb begin
        proximo   = estado;
        anodos    = 2'b11;
        segmentos = SEG_APAGADO;

        case (estado)
            EXIBE_UNI: begin
                anodos    = 2'b10;
                segmentos = seg_decod;
                if (contagem == FIM_EXIBE) begin
                    proximo = (GUARDA == 0) ? EXIBE_DEZ : APAGA_1;
                end
            end
            APAGA_1: begin
                if (contagem == FIM_APAGA) begin
                    proximo = EXIBE_DEZ;
                end
            end
            EXIBE_DEZ: begin
                anodos = 2'b01;
                if ((SUPRIME_ZERO != 0) && (digito_dez == 4'd0)) begin
                    segmentos = SEG_APAGADO;
                end else begin
                    segmentos = seg_decod;
                end
                if (contagem == FIM_EXIBE) begin
                    proximo = (GUARDA == 0) ? EXIBE_UNI : APAGA_2;
                end
            end
            APAGA_2: begin
                if (contagem == FIM_APAGA) begin
                    proximo = EXIBE_UNI;
                end
            end
            default: begin
                proximo = EXIBE_UNI;
            end
        endcase

        if (saida_bloqueada) begin
            anodos    = 2'b11;
            segmentos = SEG_APAGADO;
        end
    end

endmodule

// File: tb/tb_modulo_decodificador_display_garrafas.sv
// ---------------------------------------------------------------------------
// Directed bench for modulo_decodificador_display_garrafas.
// dut   : DIVISOR=4, GUARDA=1, SUPRIME_ZERO=1 (scan period 10)
// dut_b : DIVISOR=4, GUARDA=0, SUPRIME_ZERO=0 (scan period 8)
// dut_c : DIVISOR=1, GUARDA=1, SUPRIME_ZERO=1 (scan period 4)
// All three share clock and inputs. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, away from the edge.
// "phase" counts cycles since the first visible units cycle after reset.
// ---------------------------------------------------------------------------
module tb_modulo_decodificador_display_garrafas;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       carregar;
    logic [3:0] cdf_unidade;
    logic [3:0] cdf_dezena;

    logic [6:0] segmentos,   segmentos_b,   segmentos_c;
    logic [1:0] anodos,      anodos_b,      anodos_c;
    logic       erro,        erro_b,        erro_c;

    int total = 0;
    int bad   = 0;

    // Active-low digit patterns 0..9, hand-copied from the segment table.
    logic [6:0] tabela [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    modulo_decodificador_display_garrafas #(.DIVISOR(4), .GUARDA(1), .SUPRIME_ZERO(1)) dut (
        .clk(clk), .reset_n(reset_n), .carregar(carregar),
        .cdf_unidade(cdf_unidade), .cdf_dezena(cdf_dezena),
        .segmentos(segmentos), .anodos(anodos), .erro(erro)
    );

    modulo_decodificador_display_garrafas #(.DIVISOR(4), .GUARDA(0), .SUPRIME_ZERO(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .carregar(carregar),
        .cdf_unidade(cdf_unidade), .cdf_dezena(cdf_dezena),
        .segmentos(segmentos_b), .anodos(anodos_b), .erro(erro_b)
    );

    modulo_decodificador_display_garrafas #(.DIVISOR(1), .GUARDA(1), .SUPRIME_ZERO(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .carregar(carregar),
        .cdf_unidade(cdf_unidade), .cdf_dezena(cdf_dezena),
        .segmentos(segmentos_c), .anodos(anodos_c), .erro(erro_c)
    );

    // Expected {anodos, segmentos} of dut at a given phase of the 10-cycle scan.
    function automatic logic [8:0] esperado(input int fase, input logic [6:0] su, input logic [6:0] sd);
        int p;
        p = fase % 10;
        if (p < 4)       return {2'b10, su};
        else if (p == 4) return {2'b11, 7'h7F};
        else if (p < 9)  return {2'b01, sd};
        else             return {2'b11, 7'h7F};
    endfunction

    task automatic passo();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge, release, and land on phase 0 (units slot, count 0).
    task automatic faz_reset();
        reset_n  = 1'b0;
        carregar = 1'b0;
        passo();
        reset_n = 1'b1;
        passo();
    endtask

    task automatic test_reset();
        logic [8:0] exp_v;
        reset_n     = 1'b0;
        carregar    = 1'b0;
        cdf_unidade = 4'd0;
        cdf_dezena  = 4'd0;
        for (int i = 0; i < 3; i++) begin
            passo();
            total++;
            if ({anodos, segmentos, erro} !== {2'b11, 7'h7F, 1'b0}) begin
                bad++;
                $display("[TB] FAIL reset_dark cyc%0d: got an=%b seg=%h erro=%b want an=11 seg=7f erro=0", i, anodos, segmentos, erro);
            end
        end
        reset_n = 1'b1;
        passo();
        for (int f = 0; f < 20; f++) begin
            exp_v = esperado(f, 7'h40, 7'h7F);
            total++;
            if ({anodos, segmentos} !== exp_v) begin
                bad++;
                $display("[TB] FAIL reset_scan ph%0d: got an=%b seg=%h want an=%b seg=%h", f, anodos, segmentos, exp_v[8:7], exp_v[6:0]);
            end
            passo();
        end
    endtask

    task automatic test_carga();
        logic [8:0] exp_v;
        faz_reset();
        carregar = 1'b1; cdf_unidade = 4'd7; cdf_dezena = 4'd4;
        passo();
        carregar = 1'b0;
        for (int f = 1; f <= 10; f++) begin
            exp_v = esperado(f, 7'h78, 7'h19);
            total++;
            if ({anodos, segmentos, erro} !== {exp_v, 1'b0}) begin
                bad++;
                $display("[TB] FAIL load_74 ph%0d: got an=%b seg=%h erro=%b want an=%b seg=%h erro=0", f, anodos, segmentos, erro, exp_v[8:7], exp_v[6:0]);
            end
            passo();
        end
    endtask

    task automatic test_invalido();
        logic [8:0] exp_v;
        faz_reset();
        carregar = 1'b1; cdf_unidade = 4'd12; cdf_dezena = 4'd3;
        passo();
        carregar = 1'b0;
        for (int f = 1; f <= 10; f++) begin
            exp_v = esperado(f, 7'h3F, 7'h30);
            total++;
            if ({anodos, segmentos, erro} !== {exp_v, 1'b1}) begin
                bad++;
                $display("[TB] FAIL invalid_unit ph%0d: got an=%b seg=%h erro=%b want an=%b seg=%h erro=1", f, anodos, segmentos, erro, exp_v[8:7], exp_v[6:0]);
            end
            passo();
        end
        carregar = 1'b1; cdf_unidade = 4'd5; cdf_dezena = 4'd9;
        passo();
        carregar = 1'b0;
        for (int f = 12; f <= 21; f++) begin
            exp_v = esperado(f, 7'h12, 7'h10);
            total++;
            if ({anodos, segmentos, erro} !== {exp_v, 1'b0}) begin
                bad++;
                $display("[TB] FAIL recover_59 ph%0d: got an=%b seg=%h erro=%b want an=%b seg=%h erro=0", f, anodos, segmentos, erro, exp_v[8:7], exp_v[6:0]);
            end
            passo();
        end
    endtask

    task automatic test_meio_slot();
        faz_reset();
        passo();
        passo();
        total++;
        if ({anodos, segmentos} !== {2'b10, 7'h40}) begin
            bad++;
            $display("[TB] FAIL midslot_before: got an=%b seg=%h want an=10 seg=40", anodos, segmentos);
        end
        carregar = 1'b1; cdf_unidade = 4'd8; cdf_dezena = 4'd1;
        passo();
        carregar = 1'b0;
        total++;
        if ({anodos, segmentos} !== {2'b10, 7'h00}) begin
            bad++;
            $display("[TB] FAIL midslot_new: got an=%b seg=%h want an=10 seg=00", anodos, segmentos);
        end
        passo();
        total++;
        if ({anodos, segmentos} !== {2'b11, 7'h7F}) begin
            bad++;
            $display("[TB] FAIL midslot_end: got an=%b seg=%h want an=11 seg=7f", anodos, segmentos);
        end
        passo();
        total++;
        if ({anodos, segmentos} !== {2'b01, 7'h79}) begin
            bad++;
            $display("[TB] FAIL midslot_tens: got an=%b seg=%h want an=01 seg=79", anodos, segmentos);
        end
    endtask

    task automatic test_reset_meio();
        logic [8:0] exp_v;
        faz_reset();
        carregar = 1'b1; cdf_unidade = 4'd13; cdf_dezena = 4'd2;
        passo();
        carregar = 1'b0;
        for (int f = 1; f < 6; f++) passo();
        total++;
        if ({anodos, segmentos, erro} !== {2'b01, 7'h24, 1'b1}) begin
            bad++;
            $display("[TB] FAIL midreset_pre: got an=%b seg=%h erro=%b want an=01 seg=24 erro=1", anodos, segmentos, erro);
        end
        reset_n = 1'b0;
        passo();
        reset_n = 1'b1;
        total++;
        if ({anodos, segmentos, erro} !== {2'b11, 7'h7F, 1'b0}) begin
            bad++;
            $display("[TB] FAIL midreset_dark: got an=%b seg=%h erro=%b want an=11 seg=7f erro=0", anodos, segmentos, erro);
        end
        passo();
        for (int f = 0; f <= 5; f++) begin
            exp_v = esperado(f, 7'h40, 7'h7F);
            total++;
            if ({anodos, segmentos, erro} !== {exp_v, 1'b0}) begin
                bad++;
                $display("[TB] FAIL midreset_scan ph%0d: got an=%b seg=%h erro=%b want an=%b seg=%h erro=0", f, anodos, segmentos, erro, exp_v[8:7], exp_v[6:0]);
            end
            passo();
        end
    endtask

    task automatic test_sem_guarda();
        logic [8:0] exp_v;
        faz_reset();
        carregar = 1'b1; cdf_unidade = 4'd7; cdf_dezena = 4'd0;
        passo();
        carregar = 1'b0;
        for (int f = 1; f <= 16; f++) begin
            exp_v = ((f % 8) < 4) ? {2'b10, 7'h78} : {2'b01, 7'h40};
            total++;
            if ({anodos_b, segmentos_b} !== exp_v) begin
                bad++;
                $display("[TB] FAIL noguard ph%0d: got an=%b seg=%h want an=%b seg=%h", f, anodos_b, segmentos_b, exp_v[8:7], exp_v[6:0]);
            end
            passo();
        end
    endtask

    task automatic test_divisor_um();
        logic [8:0] exp_v;
        faz_reset();
        carregar = 1'b1; cdf_unidade = 4'd7; cdf_dezena = 4'd0;
        passo();
        carregar = 1'b0;
        for (int f = 1; f <= 8; f++) begin
            case (f % 4)
                0:       exp_v = {2'b10, 7'h78};
                2:       exp_v = {2'b01, 7'h7F};
                default: exp_v = {2'b11, 7'h7F};
            endcase
            total++;
            if ({anodos_c, segmentos_c} !== exp_v) begin
                bad++;
                $display("[TB] FAIL div1 ph%0d: got an=%b seg=%h want an=%b seg=%h", f, anodos_c, segmentos_c, exp_v[8:7], exp_v[6:0]);
            end
            passo();
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_v;
        logic [3:0] u;
        faz_reset();
        for (int i = 0; i < 6; i++) begin
            u = 4'(i);
            carregar = 1'b1; cdf_unidade = u; cdf_dezena = u + 4'd1;
            passo();
            exp_v = esperado(i + 1, tabela[i], tabela[i + 1]);
            total++;
            if ({anodos, segmentos, erro} !== {exp_v, 1'b0}) begin
                bad++;
                $display("[TB] FAIL b2b ph%0d: got an=%b seg=%h erro=%b want an=%b seg=%h erro=0", i + 1, anodos, segmentos, erro, exp_v[8:7], exp_v[6:0]);
            end
        end
        carregar = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_carga();
        test_invalido();
        test_meio_slot();
        test_reset_meio();
        test_sem_guarda();
        test_divisor_um();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
